// File: rtl/key_scan_04.sv
// key_scan_04: debounces 4 active-low push keys into press/release/long-press events
//   clk, rst          clock, asynchronous active-high reset
//   key_in[3:0]       raw key pins, active-low, asynchronous to clk
//   key_state[3:0]    debounced level per key (1 = pressed)
//   key_press[3:0]    1-cycle pulse on debounced press
//   key_release[3:0]  1-cycle pulse on debounced release
//   key_long[3:0]     1-cycle pulse once per press after LONG_CYCLES held
//   key_valid         1-cycle pulse when any key_press bit is high
//   key_code[1:0]     lowest pressed index, 0 when key_valid is low
module key_scan_04 #(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic       key_valid,
    output logic [1:0] key_code
);
    typedef enum logic [1:0] {IDLE, PDEB, HELD, RDEB} state_t;
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
    logic [3:0] sync_q, ks_q;
    state_t state_q [4];
    state_t state_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] dcnt_q [4];
    logic [CNT_W-1:0] dcnt_d [4];
    logic [3:0] long_done_q, long_done_d;
    logic [3:0] key_state_q, key_state_d;
    logic [3:0] press_q, press_d;
    logic [3:0] release_q, release_d;
    logic [3:0] long_q, long_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        long_done_d = long_done_q;
        key_state_d = key_state_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (!ks_q[i]) begin
                        state_d[i] = PDEB;
                        cnt_d[i]   = '0;
                    end
                end
                PDEB: begin
                    if (ks_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == DEB_MAX) begin
                        state_d[i]     = HELD;
                        cnt_d[i]       = '0;
                        press_d[i]     = 1'b1;
                        key_state_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    // Hold timer runs through HELD and RDEB alike and parks at its
                    // limit so key_long can fire only once per press.
                    if (cnt_q[i] == LONG_MAX) begin
                        if (!long_done_q[i]) begin
                            long_d[i]      = 1'b1;
                            long_done_d[i] = 1'b1;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                    if (state_q[i] == HELD) begin
                        if (ks_q[i]) begin
                            state_d[i] = RDEB;
                            dcnt_d[i]  = '0;
                        end
                    end else if (!ks_q[i]) begin
                        state_d[i] = HELD;
                    end else if (dcnt_q[i] == DEB_MAX) begin
                        state_d[i]     = IDLE;
                        release_d[i]   = 1'b1;
                        key_state_d[i] = 1'b0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 1'b1;
                    end
                end
            endcase
        end
        valid_d = |press_d;
        code_d  = press_d[0] ? 2'd0 : press_d[1] ? 2'd1 : press_d[2] ? 2'd2 : press_d[3] ? 2'd3 : 2'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            ks_q        <= '1;
            long_done_q <= '0;
            key_state_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                dcnt_q[i]  <= '0;
            end
        end else begin
            sync_q      <= key_in;
            ks_q        <= sync_q;
            long_done_q <= long_done_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                dcnt_q[i]  <= dcnt_d[i];
            end
        end
    end
    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_valid   = valid_q;
    assign key_code    = code_q;
endmodule
